// File: rtl/pbvi_pkg.sv
// Shared types and helpers for the PBVI belief-update datapath.
// Defaults describe the 2-state / 3-action / 2-observation engine.
package pbvi_pkg;

  localparam int N_STATES_DEF  = 2;
  localparam int N_ACTIONS_DEF = 3;
  localparam int N_OBS_DEF     = 2;
  localparam int W_DEF         = 16;
  localparam int ONE           = 2 ** (W_DEF - 1);

  typedef logic [W_DEF-1:0] prob_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREDICT,
    ST_WEIGHT,
    ST_CHECK,
    ST_DIVIDE,
    ST_DONE
  } belief_state_e;

  // Clamp an unsigned value to 1.0 in Q1.(w-1).
  function automatic logic [63:0] sat_one(input logic [63:0] v, input int unsigned w);
    logic [63:0] one;
    one = 64'd1 << (w - 1);
    return (v > one) ? one : v;
  endfunction

endpackage

// File: rtl/pbvi_serial_div.sv
// Restoring divider: W-bit quotient of a (2W-1)-bit dividend, one bit per cycle.
// The upper W-1 dividend bits seed the remainder; if they already reach the divisor the quotient saturates.
module pbvi_serial_div
  import pbvi_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_STATES_DEF,
  localparam int DW = W + $clog2(N),
  localparam int CW = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [2*W-2:0]  i_dividend,
  input  logic [DW-1:0]   i_divisor,
  output logic            o_done,
  output logic [W-1:0]    o_quot
);

  localparam logic [W-1:0] ONE_W = {1'b1, {(W-1){1'b0}}};

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_rem;
  logic [DW-1:0] r_dvs;
  logic [W-1:0]  r_dvd;
  logic [W-2:0]  r_quo;
  logic          r_sat;

  logic [DW:0]   w_rem_sh;
  logic [DW:0]   w_rem_sub;
  logic          w_ge;
  logic [DW-1:0] w_rem_nxt;
  logic [W-1:0]  w_quo_nxt;

  always_comb begin
    w_rem_sh  = {r_rem, r_dvd[W-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    w_rem_sub = w_rem_sh - {1'b0, r_dvs};
    w_rem_nxt = w_ge ? w_rem_sub[DW-1:0] : w_rem_sh[DW-1:0];
    w_quo_nxt = {r_quo, w_ge};
  end

  // Done and quotient are combinational on the final iteration so the caller can restart immediately.
  assign o_done = r_busy && (r_cnt == CW'(W - 1));
  assign o_quot = r_sat ? ONE_W : W'(sat_one(64'(w_quo_nxt), W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_dvd  <= '0;
      r_quo  <= '0;
      r_sat  <= 1'b0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= DW'(i_dividend[2*W-2:W]);
      r_sat  <= (DW'(i_dividend[2*W-2:W]) >= i_divisor);
      r_dvs  <= i_divisor;
      r_dvd  <= i_dividend[W-1:0];
      r_quo  <= '0;
    end else if (r_busy) begin
      r_rem <= w_rem_nxt;
      r_dvd <= r_dvd << 1;
      r_quo <= w_quo_nxt[W-2:0];
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pbvi_belief_update.sv
// Sequential POMDP belief update: predict through T, weight by O, normalise with a serial divider.
// start is taken only when busy is low (IDLE or DONE); done pulses for one cycle with result and flags valid.
module pbvi_belief_update
  import pbvi_pkg::*;
#(
  parameter int N_STATES  = N_STATES_DEF,
  parameter int N_ACTIONS = N_ACTIONS_DEF,
  parameter int N_OBS     = N_OBS_DEF,
  parameter int W         = W_DEF,
  localparam int FRAC = W - 1,
  localparam int AW   = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1,
  localparam int OW   = (N_OBS > 1) ? $clog2(N_OBS) : 1,
  localparam int SW   = $clog2(N_STATES),
  localparam int ACCW = 2 * W + SW,
  localparam int TW   = W + SW
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  start,
  input  logic [N_ACTIONS-1:0][N_STATES-1:0][N_STATES-1:0][W-1:0] trans,
  input  logic [N_ACTIONS-1:0][N_STATES-1:0][N_OBS-1:0][W-1:0]    observe,
  input  logic [N_STATES-1:0][W-1:0]                            current_belief,
  input  logic [AW-1:0]                                         action,
  input  logic [OW-1:0]                                         observation,
  output logic                                                  busy,
  output logic                                                  done,
  output logic [N_STATES-1:0][W-1:0]                            renew_belief,
  output logic                                                  degenerate,
  output logic                                                  err,
  output belief_state_e                                         o_dbg_state
);

  localparam logic [SW-1:0] LAST = SW'(N_STATES - 1);

  belief_state_e r_state, w_state_nxt;

  logic [AW-1:0]               r_action;
  logic [OW-1:0]               r_obs;
  logic [N_STATES-1:0][W-1:0]  r_belief, r_t, r_o, r_q, r_renew;
  logic [SW-1:0]               r_i, r_j;
  logic [ACCW-1:0]             r_acc;
  logic [TW-1:0]               r_total;
  logic                        r_degen, r_err;

  logic                        w_accept, w_range_bad;
  logic [W-1:0]                w_mul_a, w_mul_b;
  logic [2*W-1:0]              w_prod;
  logic [ACCW-1:0]             w_acc_next;
  logic [W-1:0]                w_t_val, w_o_val;
  logic [TW-1:0]               w_total_next;
  logic                        w_div_start, w_div_done;
  logic [SW-1:0]               w_div_sel;
  logic [2*W-2:0]              w_div_dividend;
  logic [W-1:0]                w_div_quot;
  logic [N_STATES-1:0][W-1:0]  w_q_final;

  assign w_accept    = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_range_bad = (32'(action) >= N_ACTIONS) || (32'(observation) >= N_OBS);

  // The single multiplier serves T*b during PREDICT and O*t during WEIGHT.
  always_comb begin
    w_mul_a = trans[r_action][r_i][r_j];
    w_mul_b = r_belief[r_i];
    if (r_state == ST_WEIGHT) begin
      w_mul_a = observe[r_action][r_j][r_obs];
      w_mul_b = r_t[r_j];
    end
  end

  assign w_prod       = {{W{1'b0}}, w_mul_a} * {{W{1'b0}}, w_mul_b};
  assign w_acc_next   = r_acc + {{SW{1'b0}}, w_prod};
  assign w_t_val      = W'(sat_one(64'(w_acc_next >> FRAC), W));
  assign w_o_val      = W'(sat_one(64'(w_prod >> FRAC), W));
  assign w_total_next = r_total + TW'(w_o_val);

  // The next state's division is launched in the same cycle the previous one finishes.
  always_comb begin
    w_div_start = 1'b0;
    w_div_sel   = '0;
    if (r_state == ST_CHECK && r_total != '0) begin
      w_div_start = 1'b1;
    end else if (r_state == ST_DIVIDE && w_div_done && r_j != LAST) begin
      w_div_start = 1'b1;
      w_div_sel   = r_j + SW'(1);
    end
  end

  assign w_div_dividend = {r_o[w_div_sel], {FRAC{1'b0}}};

  pbvi_serial_div #(.W(W), .N(N_STATES)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_div_dividend),
    .i_divisor  (r_total),
    .o_done     (w_div_done),
    .o_quot     (w_div_quot)
  );

  always_comb begin
    w_q_final      = r_q;
    w_q_final[r_j] = w_div_quot;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = w_range_bad ? ST_DONE : ST_PREDICT;
      ST_PREDICT: if (r_i == LAST && r_j == LAST) w_state_nxt = ST_WEIGHT;
      ST_WEIGHT:  if (r_j == LAST) w_state_nxt = ST_CHECK;
      ST_CHECK:   w_state_nxt = (r_total == '0) ? ST_DONE : ST_DIVIDE;
      ST_DIVIDE:  if (w_div_done && r_j == LAST) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = start ? (w_range_bad ? ST_DONE : ST_PREDICT) : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_action <= '0;
      r_obs    <= '0;
      r_belief <= '0;
      r_t      <= '0;
      r_o      <= '0;
      r_q      <= '0;
      r_renew  <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_acc    <= '0;
      r_total  <= '0;
      r_degen  <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_action <= action;
      r_obs    <= observation;
      r_belief <= current_belief;
      r_i      <= '0;
      r_j      <= '0;
      r_acc    <= '0;
      r_total  <= '0;
      if (w_range_bad) begin
        r_err   <= 1'b1;
        r_degen <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_PREDICT: begin
          if (r_i == LAST) begin
            r_t[r_j] <= w_t_val;
            r_acc    <= '0;
            r_i      <= '0;
            r_j      <= (r_j == LAST) ? '0 : r_j + SW'(1);
          end else begin
            r_acc <= w_acc_next;
            r_i   <= r_i + SW'(1);
          end
        end
        ST_WEIGHT: begin
          r_o[r_j] <= w_o_val;
          r_total  <= w_total_next;
          r_j      <= (r_j == LAST) ? '0 : r_j + SW'(1);
        end
        ST_CHECK: begin
          if (r_total == '0) begin
            r_degen <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        ST_DIVIDE: begin
          if (w_div_done) begin
            r_q[r_j] <= w_div_quot;
            if (r_j == LAST) begin
              r_renew <= w_q_final;
              r_degen <= 1'b0;
              r_err   <= 1'b0;
            end else begin
              r_j <= r_j + SW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done         = (r_state == ST_DONE);
  assign renew_belief = r_renew;
  assign degenerate   = r_degen;
  assign err          = r_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pbvi_belief_update.sv
// Directed and randomised checks of pbvi_belief_update at default parameters.
// Expected {degenerate, err, renew} words and latencies are queued at issue and compared at done.
module tb_pbvi_belief_update;
  import pbvi_pkg::*;

  localparam int NS = 2;
  localparam int NA = 3;
  localparam int NO = 2;
  localparam int W  = 16;
  localparam int EW = 2 * W + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [NA-1:0][NS-1:0][NS-1:0][W-1:0] trans;
  logic [NA-1:0][NS-1:0][NO-1:0][W-1:0] observe;
  logic [NS-1:0][W-1:0] current_belief;
  logic [NS-1:0][W-1:0] renew_belief;
  logic [1:0] action;
  logic [0:0] observation;
  logic busy, done, degenerate, err;
  belief_state_e dbg_state;

  logic [EW-1:0] exp_q[$];
  int lat_q[$];
  logic [NS-1:0][W-1:0] model_renew;
  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  pbvi_belief_update dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .trans          (trans),
    .observe        (observe),
    .current_belief (current_belief),
    .action         (action),
    .observation    (observation),
    .busy           (busy),
    .done           (done),
    .renew_belief   (renew_belief),
    .degenerate     (degenerate),
    .err            (err),
    .o_dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called 1 time unit after a rising edge; returns in cycle 1 of the new update.
  task automatic issue(input logic [1:0] a, input logic o, input prob_t b0, input prob_t b1);
    action            = a;
    observation       = o;
    current_belief[0] = b0;
    current_belief[1] = b1;
    start             = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_result(input prob_t r0, input prob_t r1, input logic dg, input logic er,
                               input int elat);
    exp_q.push_back({dg, er, r1, r0});
    lat_q.push_back(elat);
    model_renew[0] = r0;
    model_renew[1] = r1;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int n = 1; n <= 100; n++) begin
      if (done) begin
        l = n;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic score(input string tag, input int l);
    logic [EW-1:0] e;
    int el;
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    check({tag, "_result"}, 64'({degenerate, err, renew_belief[1], renew_belief[0]}), 64'(e));
    check({tag, "_latency"}, 64'(l), 64'(el));
  endtask

  // Reference model of the update equations on the bench's own T/O tables.
  function automatic logic [EW-1:0] model(input int a, input int o, input prob_t b0, input prob_t b1,
                                          output int elat);
    longint b[2];
    longint t[2];
    longint ov[2];
    longint acc, tot, q0, q1;
    b[0] = longint'(b0);
    b[1] = longint'(b1);
    tot  = 0;
    for (int j = 0; j < NS; j++) begin
      acc = 0;
      for (int i = 0; i < NS; i++) acc += longint'(trans[a][i][j]) * b[i];
      t[j] = acc >> 15;
      if (t[j] > 32768) t[j] = 32768;
      ov[j] = (longint'(observe[a][j][o]) * t[j]) >> 15;
      if (ov[j] > 32768) ov[j] = 32768;
      tot += ov[j];
    end
    if (tot == 0) begin
      elat = 8;
      return {1'b1, 1'b0, model_renew[1], model_renew[0]};
    end
    q0 = (ov[0] << 15) / tot;
    q1 = (ov[1] << 15) / tot;
    if (q0 > 32768) q0 = 32768;
    if (q1 > 32768) q1 = 32768;
    elat = 40;
    return {2'b00, W'(q1), W'(q0)};
  endfunction

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    action         = '0;
    observation    = '0;
    current_belief = '0;
    trans          = '0;
    observe        = '0;
    model_renew    = '0;
    trans[0][0][0] = 16'h8000;
    trans[0][1][1] = 16'h8000;
    for (int a = 1; a < NA; a++)
      for (int i = 0; i < NS; i++) begin
        for (int j = 0; j < NS; j++) trans[a][i][j] = W'($urandom_range(0, 32768));
        for (int o = 0; o < NO; o++) observe[a][i][o] = W'($urandom_range(0, 32768));
      end
    observe[0][0][0] = 16'h4000;
    observe[0][1][0] = 16'h4000;
    observe[0][0][1] = 16'h6000;
    observe[0][1][1] = 16'h2000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({busy, done, degenerate, err, renew_belief}), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: identity T, uniform O
    issue(2'd0, 1'b0, 16'h4000, 16'h4000);
    check("s1_busy", 64'(busy), 64'd1);
    expect_result(16'h4000, 16'h4000, 1'b0, 1'b0, 40);
    wait_done(lat);
    score("s1", lat);
    @(posedge clk); #1;
    check("s1_done_pulse", 64'(done), 64'd0);

    // 2: skewed observation column
    issue(2'd0, 1'b1, 16'h4000, 16'h4000);
    expect_result(16'h6000, 16'h2000, 1'b0, 1'b0, 40);
    wait_done(lat);
    score("s2", lat);
    @(posedge clk); #1;

    // 3: zero normaliser keeps the prior result
    observe[0][0][0] = 16'h0000;
    observe[0][1][0] = 16'h0000;
    issue(2'd0, 1'b0, 16'h4000, 16'h4000);
    expect_result(16'h6000, 16'h2000, 1'b1, 1'b0, 8);
    wait_done(lat);
    score("s3_degenerate", lat);
    @(posedge clk); #1;

    // 4: out-of-range action, then a valid update clears err
    issue(2'd3, 1'b0, 16'h4000, 16'h4000);
    expect_result(16'h6000, 16'h2000, 1'b0, 1'b1, 1);
    wait_done(lat);
    score("s4_err", lat);
    @(posedge clk); #1;
    issue(2'd0, 1'b1, 16'h2000, 16'h6000);
    expect_result(16'h4000, 16'h4000, 1'b0, 1'b0, 40);
    wait_done(lat);
    score("s4_clear", lat);
    @(posedge clk); #1;

    // Random tables for actions 1 and 2
    for (int k = 0; k < 4; k++) begin
      int ra;
      int ml;
      logic ro;
      prob_t rb0, rb1;
      logic [EW-1:0] m;
      ra  = 1 + (k % 2);
      ro  = 1'($urandom_range(0, 1));
      rb0 = W'($urandom_range(0, 32768));
      rb1 = W'($urandom_range(0, 32768));
      m   = model(ra, int'(ro), rb0, rb1, ml);
      issue(2'(ra), ro, rb0, rb1);
      expect_result(m[W-1:0], m[2*W-1:W], m[EW-1], m[EW-2], ml);
      wait_done(lat);
      score("rand", lat);
      @(posedge clk); #1;
    end

    // 5: start while busy is ignored; start in DONE is accepted
    issue(2'd0, 1'b1, 16'h4000, 16'h4000);
    expect_result(16'h6000, 16'h2000, 1'b0, 1'b0, 40);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      start = (n == 3 || n == 20);
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    score("s5_ignore", lat);
    issue(2'd0, 1'b1, 16'h2000, 16'h6000);
    expect_result(16'h4000, 16'h4000, 1'b0, 1'b0, 40);
    wait_done(lat);
    score("s5_back2back", lat);
    @(posedge clk); #1;

    // 6: reset during DIVIDE aborts without done
    issue(2'd0, 1'b1, 16'h4000, 16'h4000);
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("s6_in_divide", 64'(dbg_state), 64'(ST_DIVIDE));
    rst_n = 1'b0;
    #1;
    check("s6_reset_outputs", 64'({busy, done, degenerate, err, renew_belief}), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("s6_no_done", 64'(done), 64'd0);
    end
    rst_n       = 1'b1;
    model_renew = '0;
    @(posedge clk); #1;
    issue(2'd0, 1'b1, 16'h4000, 16'h4000);
    expect_result(16'h6000, 16'h2000, 1'b0, 1'b0, 40);
    wait_done(lat);
    score("s6_rerun", lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pbvi_belief_update.md
Name: pbvi_belief_update

Overview:
Parametrised, sequential POMDP belief-update engine for the PBVI datapath: b'(j) = O[a][j][o] * sum_i T[a][i][j]*b(i), normalised over j.
Generalises the fixed 2-state/3-action/2-observation combinational update to N_STATES/N_ACTIONS/N_OBS with a single shared multiplier, a serial divider and a start/busy/done handshake.
Sits between the policy/decision stage (supplies action, observation, current belief) and the alpha-vector evaluator (consumes the renewed belief).

Parameters:
N_STATES, 2, number of hidden states (>=2)
N_ACTIONS, 3, number of actions (>=1)
N_OBS, 2, number of observations (>=2)
W, 16, probability word width; unsigned fixed point Q1.(W-1), 1.0 = 2^(W-1)
FRAC, W-1, fractional bits (fixed by W; not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request an update; accepted only when busy=0
trans  in  W x [N_ACTIONS][N_STATES][N_STATES]  T[a][from][to]; must be stable while busy
observe  in  W x [N_ACTIONS][N_STATES][N_OBS]  O[a][state][obs]; must be stable while busy
current_belief  in  W x [N_STATES]  prior belief, sampled on accepted start
action  in  max(1,clog2(N_ACTIONS))  action index, sampled on accepted start
observation  in  max(1,clog2(N_OBS))  observation index, sampled on accepted start
busy  out  1  high from the cycle after acceptance until DONE
done  out  1  one-cycle pulse: result/flags valid
renew_belief  out  W x [N_STATES]  posterior belief; held between updates
degenerate  out  1  last update had zero normaliser; belief left unchanged
err  out  1  last update had out-of-range action/observation; belief left unchanged

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, degenerate=0, err=0, all renew_belief=0, all internal accumulators=0. Reset mid-operation aborts with no done pulse.
- FSM: IDLE -> PREDICT -> WEIGHT -> CHECK -> DIVIDE -> DONE -> IDLE.
- Acceptance: start=1 while in IDLE or DONE (busy=0). Call that cycle 0. Latch action, observation, current_belief. start while busy is ignored, with no queuing.
- Range check at acceptance: action>=N_ACTIONS or observation>=N_OBS -> go to DONE; done at cycle 1 with err=1, degenerate=0, renew_belief unchanged.
- PREDICT: N_STATES^2 cycles, one MAC/cycle, order j outer, i inner.
  - acc += T[a][i][j]*b[i] (2W+clog2(N_STATES) bits).
  - At end of each j: t[j] = acc>>FRAC, saturated to 2^(W-1). Truncate, no rounding.
- WEIGHT: N_STATES cycles; o[j] = (O[a][j][obs]*t[j])>>FRAC (truncate). Accumulate total = sum o[j] (W+clog2(N_STATES) bits, exact).
- CHECK: 1 cycle. total==0 -> DONE with degenerate=1, err=0, renew_belief unchanged.
- DIVIDE: N_STATES*W cycles; one restoring-division quotient bit per cycle per state.
  - q[j] = (o[j]<<FRAC)/total, truncated, saturated to 2^(W-1).
  - All renew_belief[j] update together on DONE entry, never partially.
- DONE: 1 cycle. done=1, busy=0. Normal completion clears degenerate and err.
- Latency from cycle 0:
  - normal: done at N_STATES^2 + N_STATES + N_STATES*W + 2 (=40 for defaults)
  - degenerate: done at N_STATES^2 + N_STATES + 2 (=8 for defaults)
  - err: done at 1
- Back-to-back: start asserted in the DONE cycle is accepted; that cycle is the new cycle 0.
- Sum of renew_belief may be below 1.0 by up to N_STATES LSB due to truncation. This is accepted behaviour.

Decomposition:
- Package pbvi_pkg holds:
  - localparams for default N_STATES/N_ACTIONS/N_OBS/W and ONE = 2^(W-1)
  - prob_t (logic [W-1:0])
  - belief-FSM state enum
  - helper function sat_one() for clamping to 1.0
- One sub-module: pbvi_serial_div. Unsigned restoring divider with start/done; dividend 2W-1 bits, divisor W+clog2(N) bits, W-bit saturated quotient, W cycles. Instantiated once and reused per state.

Test Plan:
1. Identity T[0], O[0][*][0]=0x4000, b=[0x4000,0x4000], a=0, o=0 -> done at cycle 40; renew=[0x4000,0x4000]; flags 0.
2. Identity T[0], O[0][0][1]=0x6000, O[0][1][1]=0x2000, b=[0x4000,0x4000], o=1 -> renew=[0x6000,0x2000].
3. O[0][*][0]=0 with a prior renew of [0x6000,0x2000] -> done at cycle 8; degenerate=1; renew stays [0x6000,0x2000].
4. action=3 (N_ACTIONS=3) -> done at cycle 1; err=1; renew unchanged. A following valid update clears err.
5. start pulsed during PREDICT and DIVIDE -> ignored; exactly one done at cycle 40. Then start in the DONE cycle -> second done exactly 40 cycles later.
6. rst_n low during DIVIDE -> busy/done/flags/renew all 0 immediately, no done pulse. Next start completes normally (rerun scenario 2 -> [0x6000,0x2000]).
